// File: rtl/alu_muldiv.sv
// ALU with iterative M-extension unit: single-cycle base ops, shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            zero
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_opnd;
  logic [2:0]        r_op;
  logic              r_neg;
  logic              r_remNeg;
  logic [XLEN-1:0]   r_out;
  logic              r_zero;

  logic            w_accept;
  logic            w_isM;
  logic            w_isMul;
  logic            w_isDiv;
  logic            w_divZero;
  logic            w_ovf;
  logic            w_bypass;
  logic            w_quick;
  logic            w_xSigned;
  logic            w_ySigned;
  logic            w_xNeg;
  logic            w_yNeg;
  logic [XLEN-1:0] w_xMag;
  logic [XLEN-1:0] w_yMag;
  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_aluRes;
  logic [XLEN-1:0] w_bypassRes;
  logic [XLEN-1:0] w_quickRes;
  logic            w_lastIter;

  logic [XLEN:0]     w_mulSum;
  logic [2*XLEN-1:0] w_prodNext;
  logic [2*XLEN-1:0] w_prodSigned;
  logic [XLEN-1:0]   w_mulRes;

  logic [XLEN:0]   w_divShift;
  logic [XLEN:0]   w_divTrial;
  logic [XLEN-1:0] w_remNext;
  logic [XLEN-1:0] w_quotNext;
  logic [XLEN-1:0] w_divRes;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out       = r_out;
  assign zero      = r_zero;

  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_isM      = (funct7 == 7'b0000001);
  assign w_isMul    = w_isM && !funct3[2];
  assign w_isDiv    = w_isM && funct3[2];
  assign w_divZero  = (y == '0);
  assign w_ovf      = !funct3[0] && (x == {1'b1, {(XLEN-1){1'b0}}}) && (y == '1);
  assign w_bypass   = w_isDiv && (w_divZero || w_ovf);
  assign w_quick    = !w_isM || w_bypass;
  assign w_shamt    = y[SW-1:0];
  assign w_lastIter = (r_cnt == CW'(1));

  // MUL is treated as unsigned: the low half of the product does not depend on signedness.
  always_comb begin
    w_xSigned = 1'b0;
    w_ySigned = 1'b0;
    if (w_isMul) begin
      w_xSigned = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
      w_ySigned = (funct3[1:0] == 2'b01);
    end else begin
      w_xSigned = !funct3[0];
      w_ySigned = !funct3[0];
    end
  end

  assign w_xNeg = w_xSigned && x[XLEN-1];
  assign w_yNeg = w_ySigned && y[XLEN-1];
  assign w_xMag = w_xNeg ? (~x + 1'b1) : x;
  assign w_yMag = w_yNeg ? (~y + 1'b1) : y;

  always_comb begin
    w_aluRes = '0;
    case (funct3)
      3'b000:  w_aluRes = funct7[5] ? (x - y) : (x + y);
      3'b001:  w_aluRes = x << w_shamt;
      3'b010:  w_aluRes = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      3'b011:  w_aluRes = {{(XLEN-1){1'b0}}, (x < y)};
      3'b100:  w_aluRes = x ^ y;
      3'b101:  w_aluRes = funct7[5] ? $unsigned($signed(x) >>> w_shamt) : (x >> w_shamt);
      3'b110:  w_aluRes = x | y;
      default: w_aluRes = x & y;
    endcase
  end

  always_comb begin
    w_bypassRes = '0;
    if (w_divZero) w_bypassRes = funct3[1] ? x : '1;
    else           w_bypassRes = funct3[1] ? '0 : x;
  end

  assign w_quickRes = w_isM ? w_bypassRes : w_aluRes;

  // Shift-add: low half starts as the multiplier and drains out as the product shifts in.
  assign w_mulSum     = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
  assign w_prodNext   = {w_mulSum, r_prod[XLEN-1:1]};
  assign w_prodSigned = r_neg ? (~w_prodNext + 1'b1) : w_prodNext;
  assign w_mulRes     = (r_op[1:0] == 2'b00) ? w_prodSigned[XLEN-1:0]
                                             : w_prodSigned[2*XLEN-1:XLEN];

  // Restoring divide: upper half is the partial remainder, lower half the dividend/quotient.
  assign w_divShift = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
  assign w_divTrial = w_divShift - {1'b0, r_opnd};
  assign w_remNext  = w_divTrial[XLEN] ? w_divShift[XLEN-1:0] : w_divTrial[XLEN-1:0];
  assign w_quotNext = {r_prod[XLEN-2:0], ~w_divTrial[XLEN]};
  assign w_divRes   = r_op[1] ? (r_remNeg ? (~w_remNext + 1'b1) : w_remNext)
                              : (r_neg ? (~w_quotNext + 1'b1) : w_quotNext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_quick)      w_stateNext = DONE;
          else if (w_isMul) w_stateNext = MUL;
          else              w_stateNext = DIV;
        end
      end
      MUL, DIV: if (w_lastIter) w_stateNext = DONE;
      DONE:     if (out_ready) w_stateNext = IDLE;
      default:  w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_prod   <= '0;
      r_opnd   <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_remNeg <= 1'b0;
      r_out    <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= funct3;
            r_neg    <= w_xNeg ^ w_yNeg;
            r_remNeg <= w_xNeg;
            r_cnt    <= CW'(XLEN);
            r_opnd   <= w_isMul ? w_xMag : w_yMag;
            r_prod   <= {{XLEN{1'b0}}, (w_isMul ? w_yMag : w_xMag)};
            if (w_quick) begin
              r_out  <= w_quickRes;
              r_zero <= (w_quickRes == '0);
            end
          end
        end
        MUL: begin
          r_prod <= w_prodNext;
          r_cnt  <= r_cnt - CW'(1);
          if (w_lastIter) begin
            r_out  <= w_mulRes;
            r_zero <= (w_mulRes == '0);
          end
        end
        DIV: begin
          r_prod <= {w_remNext, w_quotNext};
          r_cnt  <= r_cnt - CW'(1);
          if (w_lastIter) begin
            r_out  <= w_divRes;
            r_zero <= (w_divRes == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed testbench for alu_muldiv (XLEN = 32): hand-computed results,
// latencies, DONE hold behaviour and reset abandonment.
module tb_alu_muldiv;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [2:0]  funct3In;
  logic [6:0]  funct7In;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic        zeroFlag;

  int testsRun;
  int testsFailed;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  alu_muldiv #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .x        (opA),
    .y        (opB),
    .funct3   (funct3In),
    .funct7   (funct7In),
    .out_valid(outValid),
    .out_ready(outReady),
    .out      (outData),
    .zero     (zeroFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Waits for in_ready, presents one operation for a single accept edge, then scrambles the inputs.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] f3, input logic [6:0] f7);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (!inReady && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("acceptReady", {31'b0, inReady}, 32'd1);
    opA      = a;
    opB      = b;
    funct3In = f3;
    funct7In = f7;
    inValid  = 1'b1;
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    opA      = ~a;
    opB      = 32'hDEAD_BEEF;
    funct3In = ~f3;
    funct7In = 7'b0100000;
  endtask

  task automatic waitResult(output int latency);
    latency = 1;
    @(negedge clk);
    while (!outValid && latency < 100) begin
      @(negedge clk);
      latency++;
    end
    checkOutput("resultTimeout", {31'b0, outValid}, 32'd1);
  endtask

  task automatic runVector(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] expOut, input int expLat);
    int lat;
    applyStimulus(a, b, f3, f7);
    waitResult(lat);
    checkOutput(tag, outData, expOut);
    checkOutput({tag, "_zero"}, {31'b0, zeroFlag}, {31'b0, (expOut == 32'd0)});
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput({tag, "_idle"}, {31'b0, inReady}, 32'd1);
  endtask

  initial begin
    int lat;
    int spurious;
    testsRun    = 0;
    testsFailed = 0;
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    opA      = '0;
    opB      = '0;
    funct3In = '0;
    funct7In = '0;

    repeat (2) @(negedge clk);
    checkOutput("rstOutValid", {31'b0, outValid}, 32'd0);
    checkOutput("rstOut", outData, 32'd0);
    checkOutput("rstZero", {31'b0, zeroFlag}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstInReady", {31'b0, inReady}, 32'd1);

    runVector("add",    32'd5,          32'd7,          3'b000, F7_BASE, 32'd12,         1);
    runVector("sub",    32'd5,          32'd5,          3'b000, F7_ALT,  32'd0,          1);
    runVector("addF7",  32'd3,          32'd4,          3'b000, 7'b0000010, 32'd7,       1);
    runVector("sll",    32'd1,          32'h0000_0025,  3'b001, F7_BASE, 32'h0000_0020,  1);
    runVector("srl",    32'h8000_0000,  32'd4,          3'b101, F7_BASE, 32'h0800_0000,  1);
    runVector("sra",    32'h8000_0000,  32'h0000_0024,  3'b101, F7_ALT,  32'hF800_0000,  1);
    runVector("slt",    32'hFFFF_FFFF,  32'd1,          3'b010, F7_BASE, 32'd1,          1);
    runVector("sltu",   32'hFFFF_FFFF,  32'd1,          3'b011, F7_BASE, 32'd0,          1);
    runVector("xor",    32'hF0F0_F0F0,  32'hFF00_FF00,  3'b100, F7_BASE, 32'h0FF0_0FF0,  1);
    runVector("or",     32'hF0F0_F0F0,  32'hFF00_FF00,  3'b110, F7_BASE, 32'hFFF0_FFF0,  1);
    runVector("and",    32'hF0F0_F0F0,  32'hFF00_FF00,  3'b111, F7_BASE, 32'hF000_F000,  1);

    runVector("mulh",   32'hFFFF_FFFF,  32'd2,          3'b001, F7_M,    32'hFFFF_FFFF,  33);
    runVector("mulhu",  32'hFFFF_FFFF,  32'd2,          3'b011, F7_M,    32'h0000_0001,  33);
    runVector("mul",    32'hFFFF_FFFF,  32'd2,          3'b000, F7_M,    32'hFFFF_FFFE,  33);
    runVector("mulSm",  32'd12345,      32'd1000,       3'b000, F7_M,    32'h00BC_5EA8,  33);
    runVector("mulhsu", 32'd2,          32'hFFFF_FFFF,  3'b010, F7_M,    32'h0000_0001,  33);
    runVector("mulhsN", 32'hFFFF_FFFF,  32'd2,          3'b010, F7_M,    32'hFFFF_FFFF,  33);

    runVector("div",    32'hFFFF_FFF9,  32'd2,          3'b100, F7_M,    32'hFFFF_FFFD,  33);
    runVector("rem",    32'hFFFF_FFF9,  32'd2,          3'b110, F7_M,    32'hFFFF_FFFF,  33);
    runVector("divu",   32'd100,        32'd7,          3'b101, F7_M,    32'd14,         33);
    runVector("remu",   32'd100,        32'd7,          3'b111, F7_M,    32'd2,          33);
    runVector("div0",   32'd7,          32'd0,          3'b100, F7_M,    32'hFFFF_FFFF,  1);
    runVector("divu0",  32'd7,          32'd0,          3'b101, F7_M,    32'hFFFF_FFFF,  1);
    runVector("remu0",  32'd7,          32'd0,          3'b111, F7_M,    32'd7,          1);
    runVector("divOvf", 32'h8000_0000,  32'hFFFF_FFFF,  3'b100, F7_M,    32'h8000_0000,  1);
    runVector("remOvf", 32'h8000_0000,  32'hFFFF_FFFF,  3'b110, F7_M,    32'd0,          1);
    runVector("divuBig",32'h8000_0000,  32'hFFFF_FFFF,  3'b101, F7_M,    32'd0,          33);
    runVector("remuBig",32'h8000_0000,  32'hFFFF_FFFF,  3'b111, F7_M,    32'h8000_0000,  33);

    // Result must stay frozen in DONE while the consumer stalls and a new request waits.
    applyStimulus(32'h10, 32'h20, 3'b000, F7_BASE);
    waitResult(lat);
    opA      = 32'd1;
    opB      = 32'd1;
    funct3In = 3'b000;
    funct7In = F7_ALT;
    inValid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("holdOut", outData, 32'h30);
      checkOutput("holdZero", {31'b0, zeroFlag}, 32'd0);
      checkOutput("holdReady", {31'b0, inReady}, 32'd0);
      @(negedge clk);
    end
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput("releaseIdle", {31'b0, inReady}, 32'd1);
    checkOutput("releaseNoValid", {31'b0, outValid}, 32'd0);
    inValid = 1'b0;

    // Reset part-way through a multiply throws the operation away.
    applyStimulus(32'd3, 32'd5, 3'b000, F7_M);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midRstValid", {31'b0, outValid}, 32'd0);
    checkOutput("midRstOut", outData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("postRstReady", {31'b0, inReady}, 32'd1);
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (outValid) spurious++;
    end
    checkOutput("postRstNoResult", 32'(spurious), 32'd0);
    runVector("addAfterRst", 32'd100, 32'd23, 3'b000, F7_BASE, 32'd123, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
